// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch -- single-outstanding-request instruction fetch stage.
//
// Holds the current PC, issues one instruction-memory request at a time, and
// presents the fetched word to the downstream consumer until it is taken.
// A redirect (flush) can arrive in any state; if it lands while a memory
// response is still outstanding, the stage parks in DROP until that stale
// response has drained, so that no wrong-path word ever reaches inst.
//
// Ports
//   clk         : single clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset
//   pc_din      : next PC from the PC-select stage, taken on consume only
//   flush       : redirect request, highest priority after reset
//   flush_pc    : redirect target, taken when flush=1
//   imem_req    : instruction memory request (high in REQ)
//   imem_addr   : request address, always equal to pc
//   imem_rdy    : memory response valid (meaningful in REQ/DROP only)
//   imem_rdata  : instruction word, valid with imem_rdy
//   pc          : PC of the current/held instruction
//   npc         : pc + 4, modulo 2^32, combinational
//   inst        : held instruction word
//   inst_valid  : inst is valid for the consumer (HOLD only)
//   inst_ready  : consumer accepts inst this cycle
//   fetch_err   : one-cycle pulse after a misaligned PC load
//   fetch_cnt   : count of consumed instructions, wraps
// ---------------------------------------------------------------------------
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_din,
  input  logic             flush,
  input  logic [31:0]      flush_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rdy,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      npc,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  // Word-align a PC by clearing the two low bits.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // A PC is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [31:0]        pc_r;
  logic [31:0]        pc_s;
  logic [31:0]        inst_r;
  logic [31:0]        inst_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic               err_r;
  logic               err_s;

  logic               consume_s;
  logic               capture_s;
  logic               pc_load_s;
  logic [31:0]        pc_src_s;

  // Handshake decode: flush always overrides a consume in the same cycle.
  always_comb begin
    consume_s = 1'b0;
    capture_s = 1'b0;
    if (flush) begin
      consume_s = 1'b0;
      capture_s = 1'b0;
    end else begin
      consume_s = (state_r == ST_HOLD) && inst_ready;
      capture_s = (state_r == ST_REQ) && imem_rdy;
    end
  end

  // PC source select: redirect target wins over the consumer's next PC.
  always_comb begin
    pc_load_s = flush || consume_s;
    pc_src_s  = pc_din;
    if (flush) begin
      pc_src_s = flush_pc;
    end else begin
      pc_src_s = pc_din;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_REQ;
      end
      ST_REQ: begin
        if (flush) begin
          // A response arriving with the flush is already consumed by the
          // memory, so no drain is needed in that case.
          if (imem_rdy) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_DROP;
          end
        end else if (imem_rdy) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (flush || consume_s) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DROP: begin
        // The stale response is the only thing that ends DROP; a further
        // flush only retargets pc. If the stale response and a flush coincide
        // the response is still drained, otherwise the stage would wait for
        // a reply that never comes.
        if (imem_rdy) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: pc, held word, consume counter, error pulse.
  always_comb begin
    pc_s   = pc_r;
    inst_s = inst_r;
    cnt_s  = cnt_r;
    err_s  = 1'b0;
    if (pc_load_s) begin
      pc_s  = align_pc(pc_src_s);
      err_s = is_misaligned(pc_src_s);
    end else begin
      pc_s  = pc_r;
      err_s = 1'b0;
    end
    if (capture_s) begin
      inst_s = imem_rdata;
    end else begin
      inst_s = inst_r;
    end
    if (consume_s) begin
      cnt_s = cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r   <= RESET_PC;
      inst_r <= 32'h0000_0000;
      cnt_r  <= '0;
      err_r  <= 1'b0;
    end else begin
      pc_r   <= pc_s;
      inst_r <= inst_s;
      cnt_r  <= cnt_s;
      err_r  <= err_s;
    end
  end

  // Output decode from registered state only; no input-to-output paths
  // except the npc adder on the registered pc.
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state_r)
      ST_IDLE: begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
      end
      ST_REQ: begin
        imem_req   = 1'b1;
        inst_valid = 1'b0;
      end
      ST_HOLD: begin
        imem_req   = 1'b0;
        inst_valid = 1'b1;
      end
      ST_DROP: begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
      end
      default: begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
      end
    endcase
  end

  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign npc       = pc_r + 32'd4;
  assign inst      = inst_r;
  assign fetch_err = err_r;
  assign fetch_cnt = cnt_r;

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch -- directed, table-driven bench for pc_fetch (CNT_W=4).
// Each table row gives the inputs for one clock cycle and the outputs
// expected just after the following rising edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_din;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;
  logic [3:0]  fetch_cnt;

  int checks = 0;
  int errors = 0;

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_din     (pc_din),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .npc        (npc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc_din;
    logic        inst_ready;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_inst;
    logic        e_err;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic f, input logic [31:0] fpc, input logic [31:0] pdin,
                     input logic rdy_in, input logic mrdy, input logic [31:0] mdata,
                     input logic ereq, input logic [31:0] epc, input logic evld,
                     input logic [31:0] einst, input logic eerr, input logic [3:0] ecnt);
    vec_t v;
    v.flush = f; v.flush_pc = fpc; v.pc_din = pdin; v.inst_ready = rdy_in;
    v.imem_rdy = mrdy; v.imem_rdata = mdata;
    v.e_req = ereq; v.e_pc = epc; v.e_valid = evld; v.e_inst = einst;
    v.e_err = eerr; v.e_cnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic [31:0] fpc, input logic [31:0] pdin,
                       input logic rdy_in, input logic mrdy, input logic [31:0] mdata);
    flush = f; flush_pc = fpc; pc_din = pdin;
    inst_ready = rdy_in; imem_rdy = mrdy; imem_rdata = mdata;
  endtask

  task automatic check_all(input int idx, input logic ereq, input logic [31:0] epc,
                           input logic evld, input logic [31:0] einst,
                           input logic eerr, input logic [3:0] ecnt);
    logic [31:0] enpc;
    enpc = epc + 32'd4;
    chk("imem_req",   idx, {31'd0, imem_req},   {31'd0, ereq});
    chk("imem_addr",  idx, imem_addr,           epc);
    chk("pc",         idx, pc,                  epc);
    chk("npc",        idx, npc,                 enpc);
    chk("inst_valid", idx, {31'd0, inst_valid}, {31'd0, evld});
    chk("inst",       idx, inst,                einst);
    chk("fetch_err",  idx, {31'd0, fetch_err},  {31'd0, eerr});
    chk("fetch_cnt",  idx, {28'd0, fetch_cnt},  {28'd0, ecnt});
  endtask

  initial begin
    logic [3:0] exp_cnt;

    // Reset-release, 1-cycle memory, consume every HOLD.
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h0,   1'b0, 32'h0,  1'b0, 4'd0);
    add(1'b0, 32'h0,   32'h4,   1'b1, 1'b1, 32'h13,        1'b0, 32'h0,   1'b1, 32'h13, 1'b0, 4'd0);
    add(1'b0, 32'h0,   32'h4,   1'b1, 1'b1, 32'h13,        1'b1, 32'h4,   1'b0, 32'h13, 1'b0, 4'd1);
    add(1'b0, 32'h0,   32'h8,   1'b1, 1'b1, 32'h13,        1'b0, 32'h4,   1'b1, 32'h13, 1'b0, 4'd1);
    add(1'b0, 32'h0,   32'h8,   1'b1, 1'b1, 32'h13,        1'b1, 32'h8,   1'b0, 32'h13, 1'b0, 4'd2);
    add(1'b0, 32'h0,   32'hC,   1'b1, 1'b1, 32'h13,        1'b0, 32'h8,   1'b1, 32'h13, 1'b0, 4'd2);
    add(1'b0, 32'h0,   32'hC,   1'b1, 1'b1, 32'h13,        1'b1, 32'hC,   1'b0, 32'h13, 1'b0, 4'd3);
    // Latency-3 memory, then consumer stalls 5 cycles with stray imem_rdy.
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'hC,   1'b0, 32'h13, 1'b0, 4'd3);
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'hC,   1'b0, 32'h13, 1'b0, 4'd3);
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h33,        1'b0, 32'hC,   1'b1, 32'h33, 1'b0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      add(1'b0, 32'h0, 32'h10,  1'b0, 1'b1, 32'hBAD0_0000, 1'b0, 32'hC,   1'b1, 32'h33, 1'b0, 4'd3);
    end
    add(1'b0, 32'h0,   32'h10,  1'b1, 1'b0, 32'h0,         1'b1, 32'h10,  1'b0, 32'h33, 1'b0, 4'd4);
    // Flush beats consume in HOLD.
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h55,        1'b0, 32'h10,  1'b1, 32'h55, 1'b0, 4'd4);
    add(1'b1, 32'h100, 32'h8,   1'b1, 1'b0, 32'h0,         1'b1, 32'h100, 1'b0, 32'h55, 1'b0, 4'd4);
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h77,        1'b0, 32'h100, 1'b1, 32'h77, 1'b0, 4'd4);
    // Misaligned consume.
    add(1'b0, 32'h0,   32'h206, 1'b1, 1'b0, 32'h0,         1'b1, 32'h204, 1'b0, 32'h77, 1'b1, 4'd5);
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h204, 1'b0, 32'h77, 1'b0, 4'd5);
    // Flush in REQ without response -> DROP; misaligned re-flush in DROP.
    add(1'b1, 32'h300, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h300, 1'b0, 32'h77, 1'b0, 4'd5);
    add(1'b1, 32'h402, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h400, 1'b0, 32'h77, 1'b1, 4'd5);
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h400, 1'b0, 32'h77, 1'b0, 4'd5);
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h99,        1'b0, 32'h400, 1'b1, 32'h99, 1'b0, 4'd5);
    // Flush in REQ coinciding with a response: response discarded.
    add(1'b0, 32'h0,   32'h500, 1'b1, 1'b0, 32'h0,         1'b1, 32'h500, 1'b0, 32'h99, 1'b0, 4'd6);
    add(1'b1, 32'h600, 32'h0,   1'b0, 1'b1, 32'hAAAA,      1'b1, 32'h600, 1'b0, 32'h99, 1'b0, 4'd6);
    add(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'hBB,        1'b0, 32'h600, 1'b1, 32'hBB, 1'b0, 4'd6);

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    check_all(-1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0);

    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].flush, vq[i].flush_pc, vq[i].pc_din, vq[i].inst_ready,
            vq[i].imem_rdy, vq[i].imem_rdata);
      step();
      check_all(i, vq[i].e_req, vq[i].e_pc, vq[i].e_valid, vq[i].e_inst,
                vq[i].e_err, vq[i].e_cnt);
    end

    // Counter wrap: consume until fetch_cnt passes 15 back to 0.
    exp_cnt = 4'd6;
    for (int k = 0; k < 10; k++) begin
      logic [31:0] tgt;
      logic [31:0] word;
      tgt  = 32'h1000 + 32'(k * 4);
      word = 32'h5000 + 32'(k);
      exp_cnt = exp_cnt + 4'd1;
      drive(1'b0, 32'h0, tgt, 1'b1, 1'b0, 32'h0);
      step();
      chk("wrap_cnt", k, {28'd0, fetch_cnt}, {28'd0, exp_cnt});
      chk("wrap_addr", k, imem_addr, tgt);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, word);
      step();
      chk("wrap_inst", k, inst, word);
    end
    chk("wrap_zero", 0, {28'd0, fetch_cnt}, 32'd0);

    // Reset mid-REQ outranks a simultaneous flush.
    drive(1'b0, 32'h0, 32'h2000, 1'b1, 1'b0, 32'h0);
    step();
    check_all(100, 1'b1, 32'h2000, 1'b0, 32'h5009, 1'b0, 4'd1);
    rst_n = 1'b0;
    drive(1'b1, 32'h3000, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    check_all(101, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0);

    // Late response during IDLE ignored; misaligned flush in IDLE retargets.
    rst_n = 1'b1;
    drive(1'b1, 32'h803, 32'h0, 1'b0, 1'b1, 32'hCCCC);
    step();
    check_all(102, 1'b1, 32'h800, 1'b0, 32'h0, 1'b1, 4'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234);
    step();
    check_all(103, 1'b0, 32'h800, 1'b1, 32'h1234, 1'b0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 32, width of fetch counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 pc_din  input  32  next PC from PC select stage; sampled only on consume handshake.
REQ-006 flush  input  1  redirect request (trap/exception); highest priority.
REQ-007 flush_pc  input  32  redirect target, sampled when flush=1.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  request address, equals pc.
REQ-010 imem_rdy  input  1  memory response valid; any latency >= 1 cycle; one outstanding request.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_rdy=1.
REQ-012 pc  output  32  PC of current/held instruction.
REQ-013 npc  output  32  pc + 4, modulo 2^32, combinational.
REQ-014 inst  output  32  held instruction word.
REQ-015 inst_valid  output  1  inst is valid for consumer.
REQ-016 inst_ready  input  1  consumer accepts inst this cycle.
REQ-017 fetch_err  output  1  one-cycle pulse: misaligned PC load.
REQ-018 fetch_cnt  output  CNT_W  count of consumed instructions.

Function
REQ-019 States: IDLE, REQ, HOLD, DROP; registered state, one-hot or binary free.
REQ-020 IDLE: entered on reset; outputs quiet; next state REQ unconditionally.
REQ-021 REQ: imem_req=1, imem_addr=pc held stable until imem_rdy; on imem_rdy: inst<=imem_rdata, next HOLD.
REQ-022 HOLD: inst_valid=1, inst and pc stable; imem_req=0.
REQ-023 Consume handshake = HOLD and inst_valid and inst_ready: pc<={pc_din[31:2],2'b00}, fetch_cnt+1, next REQ; inst_valid=0 next cycle.
REQ-024 Consume with pc_din[1:0]!=0: low bits cleared as above; fetch_err=1 for exactly the next cycle.
REQ-025 Throughput: back-to-back, 1-cycle memory gives one consumed instruction every 2 cycles (REQ, HOLD).
REQ-026 flush in IDLE or HOLD: pc<=flush_pc (low bits cleared, fetch_err rules per REQ-024), inst_valid=0 next cycle, next REQ, no count.
REQ-027 flush and inst_ready same cycle in HOLD: flush wins; pc_din ignored; fetch_cnt unchanged.
REQ-028 flush in REQ with imem_rdy=1 same cycle: response discarded, pc<=flush_pc, next REQ.
REQ-029 flush in REQ with imem_rdy=0: pc<=flush_pc, next DROP; imem_req deasserted.
REQ-030 DROP: imem_req=0, inst_valid=0; wait imem_rdy, discard data, next REQ; further flush in DROP updates pc, stays DROP.
REQ-031 imem_rdy outside REQ/DROP ignored.
REQ-032 fetch_cnt wraps to 0 after all-ones; no saturation.
REQ-033 inst_valid never asserted outside HOLD; inst changes only on REQ->HOLD transition.

Reset
REQ-034 rst_n=0 at rising edge: state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, fetch_err=0, fetch_cnt=0.
REQ-035 Reset has priority over flush and all handshakes; reset mid-REQ abandons request, late imem_rdy after reset is ignored (state IDLE at that time, or response treated per REQ-031).
REQ-036 Outputs valid from first edge with rst_n=0; no async path.

Verification
REQ-037 Reset release, 1-cycle memory returning 32'h0000_0013, inst_ready=1, pc_din=npc -> imem_addr 0,4,8 on successive REQ cycles, inst=32'h13, fetch_cnt 1,2,3.
REQ-038 Memory latency 3, inst_ready held 0 for 5 cycles in HOLD -> imem_req high exactly 3 cycles, inst/pc stable throughout HOLD, no count increment.
REQ-039 HOLD, flush=1 flush_pc=32'h0000_0100 with inst_ready=1 pc_din=32'h8 -> next pc=32'h100, fetch_cnt unchanged, next imem_addr 32'h100.
REQ-040 REQ, flush with imem_rdy=0, response two cycles later data 32'hDEAD_BEEF -> state DROP, data never appears on inst, next request addr=flush_pc.
REQ-041 Consume with pc_din=32'h0000_0206 -> pc=32'h0000_0204, fetch_err high exactly one cycle.
REQ-042 Force fetch_cnt to all-ones (CNT_W=4: 15), one consume -> fetch_cnt=0.
